// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath defaults, load-size encodings
// and the big-endian byte/half lane positions within a memory word.
package mips_pkg;

   localparam int MIPS_DATA_W = 32;
   localparam int MIPS_REG_AW = 5;

   typedef enum logic [1:0] {
      LS_WORD = 2'b00,
      LS_HALF = 2'b01,
      LS_BYTE = 2'b10
   } load_size_e;

   // Big-endian: byte address 0 is the most significant byte of the word.
   localparam int BE_BYTE0_LSB = 24;
   localparam int BE_BYTE1_LSB = 16;
   localparam int BE_BYTE2_LSB = 8;
   localparam int BE_BYTE3_LSB = 0;
   localparam int BE_HALF0_LSB = 16;
   localparam int BE_HALF1_LSB = 0;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the addressed big-endian byte or
// halfword from the memory word, sign/zero-extends it and flags
// misaligned halfword/word accesses. Encoding 2'b11 is handled as a word.
module load_align
   import mips_pkg::*;
#(
   parameter int DATA_W = MIPS_DATA_W
) (
   input  logic [1:0]        i_addr,
   input  logic [DATA_W-1:0] i_word,
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   output logic [DATA_W-1:0] o_data,
   output logic              o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection, extension and alignment check.
   always_comb begin
      w_byte     = 8'h00;
      w_half     = 16'h0000;
      o_data     = i_word;
      o_misalign = 1'b0;

      case (i_addr)
         2'd0:    w_byte = i_word[BE_BYTE0_LSB +: 8];
         2'd1:    w_byte = i_word[BE_BYTE1_LSB +: 8];
         2'd2:    w_byte = i_word[BE_BYTE2_LSB +: 8];
         default: w_byte = i_word[BE_BYTE3_LSB +: 8];
      endcase

      w_half = i_addr[1] ? i_word[BE_HALF1_LSB +: 16] : i_word[BE_HALF0_LSB +: 16];

      case (load_size_e'(i_size))
         LS_BYTE: begin
            o_data = {{(DATA_W-8){~i_unsigned & w_byte[7]}}, w_byte};
         end
         LS_HALF: begin
            o_data     = {{(DATA_W-16){~i_unsigned & w_half[15]}}, w_half};
            o_misalign = i_addr[0];
         end
         default: begin
            o_data     = i_word;
            o_misalign = |i_addr;
         end
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: one registered entry from MEM, register-file write
// port generation, alignment error reporting and a retired-entry counter.
// Optional macro WB_BYPASS_EN adds two combinational forwarding ports that
// expose the value being written this cycle.
module wb_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = MIPS_DATA_W,
   parameter int REG_AW = MIPS_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
`ifdef WB_BYPASS_EN
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_fwd,
   output logic [DATA_W-1:0] rt_fwd,
   output logic              rs_hit,
   output logic              rt_hit,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic [DATA_W-1:0] pc_plus8,
   input  logic [REG_AW-1:0] dest_reg,
   input  logic              reg_write,
   input  logic              mem_to_reg,
   input  logic              link,
   input  logic              load_unsigned,
   input  logic [1:0]        load_size,
   output logic [REG_AW-1:0] writereg,
   output logic [DATA_W-1:0] writedata,
   output logic              write,
   output logic              align_err,
   output logic [31:0]       retire_cnt
);

   logic              r_valid;
   logic              r_issued;
   logic [REG_AW-1:0] r_dest;
   logic              r_reg_write;
   logic              r_mem_to_reg;
   logic              r_link;
   logic              r_unsigned;
   logic [1:0]        r_size;
   logic [DATA_W-1:0] r_alu;
   logic [DATA_W-1:0] r_mem;
   logic [DATA_W-1:0] r_pc8;
   logic [31:0]       r_retire;

   logic [DATA_W-1:0] w_load;
   logic              w_misalign;
   logic              w_present;
   logic              w_align_err;
   logic              w_write;
   logic [DATA_W-1:0] w_writedata;

   load_align #(.DATA_W(DATA_W)) u_load_align (
      .i_addr     (r_alu[1:0]),
      .i_word     (r_mem),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .o_data     (w_load),
      .o_misalign (w_misalign)
   );

   // An entry is "presented" only in its first cycle; later stall cycles re-hold it silently.
   assign w_present   = r_valid & ~r_issued;
   assign w_align_err = r_valid & r_mem_to_reg & w_misalign;
   assign w_write     = w_present & r_reg_write & ~w_align_err & (r_dest != '0);
   assign w_writedata = r_link ? r_pc8 : (r_mem_to_reg ? w_load : r_alu);

   // Stage register: flush beats stall beats capture; retire counter follows presentation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_issued     <= 1'b0;
         r_dest       <= '0;
         r_reg_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_link       <= 1'b0;
         r_unsigned   <= 1'b0;
         r_size       <= 2'b00;
         r_alu        <= '0;
         r_mem        <= '0;
         r_pc8        <= '0;
         r_retire     <= 32'd0;
      end else begin
         if (flush) begin
            r_valid  <= 1'b0;
            r_issued <= 1'b0;
         end else if (stall) begin
            r_issued <= r_issued | r_valid;
         end else begin
            r_valid  <= in_valid;
            r_issued <= 1'b0;
            if (in_valid) begin
               r_dest       <= dest_reg;
               r_reg_write  <= reg_write;
               r_mem_to_reg <= mem_to_reg;
               r_link       <= link;
               r_unsigned   <= load_unsigned;
               r_size       <= load_size;
               r_alu        <= alu_result;
               r_mem        <= mem_rd_data;
               r_pc8        <= pc_plus8;
            end
         end
         if (w_present) begin
            r_retire <= r_retire + 32'd1;
         end
      end
   end

   assign in_ready   = ~stall;
   assign writereg   = r_dest;
   assign writedata  = w_writedata;
   assign write      = w_write;
   assign align_err  = w_align_err;
   assign retire_cnt = r_retire;

`ifdef WB_BYPASS_EN
   assign rs_hit = w_write & (rs_addr == r_dest);
   assign rt_hit = w_write & (rt_addr == r_dest);
   assign rs_fwd = rs_hit ? w_writedata : '0;
   assign rt_fwd = rt_hit ? w_writedata : '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, stall, flush;
   logic        in_ready;
   logic [31:0] alu_result, mem_rd_data, pc_plus8;
   logic [4:0]  dest_reg;
   logic        reg_write, mem_to_reg, link, load_unsigned;
   logic [1:0]  load_size;
   logic [4:0]  writereg;
   logic [31:0] writedata;
   logic        write, align_err;
   logic [31:0] retire_cnt;
`ifdef WB_BYPASS_EN
   logic [4:0]  rs_addr, rt_addr;
   logic [31:0] rs_fwd, rt_fwd;
   logic        rs_hit, rt_hit;
`endif

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural model of the held entry
   logic        m_valid, m_issued;
   logic [4:0]  m_dest;
   logic        m_rw, m_mtr, m_link, m_uns;
   logic [1:0]  m_size;
   logic [31:0] m_alu, m_mem, m_pc8, m_retire;

   always #5 clk = ~clk;

   wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk           (clk),
      .rst           (rst),
`ifdef WB_BYPASS_EN
      .rs_addr       (rs_addr),
      .rt_addr       (rt_addr),
      .rs_fwd        (rs_fwd),
      .rt_fwd        (rt_fwd),
      .rs_hit        (rs_hit),
      .rt_hit        (rt_hit),
`endif
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .stall         (stall),
      .flush         (flush),
      .alu_result    (alu_result),
      .mem_rd_data   (mem_rd_data),
      .pc_plus8      (pc_plus8),
      .dest_reg      (dest_reg),
      .reg_write     (reg_write),
      .mem_to_reg    (mem_to_reg),
      .link          (link),
      .load_unsigned (load_unsigned),
      .load_size     (load_size),
      .writereg      (writereg),
      .writedata     (writedata),
      .write         (write),
      .align_err     (align_err),
      .retire_cnt    (retire_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Big-endian lane extraction done with shifts and masks.
   function automatic logic [31:0] ext_load(input logic [31:0] addr, input logic [31:0] mem,
                                             input logic [1:0] size, input logic uns);
      int          sh;
      logic [31:0] v;
      if (size == 2'b10) begin
         sh = 8 * (3 - int'(addr[1:0]));
         v  = (mem >> sh) & 32'hFF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
         return v;
      end else if (size == 2'b01) begin
         sh = 16 * (1 - int'(addr[1]));
         v  = (mem >> sh) & 32'hFFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
         return v;
      end
      return mem;
   endfunction

   function automatic logic exp_align();
      return m_valid && m_mtr &&
             ((m_size == 2'b01 && m_alu[0]) || (m_size == 2'b00 && m_alu[1:0] != 2'b00));
   endfunction

   function automatic logic exp_write();
      return m_valid && !m_issued && m_rw && !exp_align() && (m_dest != 5'd0);
   endfunction

   function automatic logic [31:0] exp_wd();
      if (m_link) return m_pc8;
      if (m_mtr)  return ext_load(m_alu, m_mem, m_size, m_uns);
      return m_alu;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_issued = 0; m_dest = 0; m_rw = 0; m_mtr = 0; m_link = 0;
      m_uns = 0; m_size = 0; m_alu = 0; m_mem = 0; m_pc8 = 0; m_retire = 0;
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else begin
         if (m_valid && !m_issued) m_retire = m_retire + 32'd1;
         if (flush) begin
            m_valid = 0; m_issued = 0;
         end else if (stall) begin
            m_issued = m_issued || m_valid;
         end else begin
            m_valid  = in_valid;
            m_issued = 0;
            if (in_valid) begin
               m_dest = dest_reg; m_rw = reg_write; m_mtr = mem_to_reg; m_link = link;
               m_uns = load_unsigned; m_size = load_size; m_alu = alu_result;
               m_mem = mem_rd_data; m_pc8 = pc_plus8;
            end
         end
      end
   endtask

   task automatic compare_outputs();
      chk("write", {31'd0, write}, {31'd0, exp_write()});
      chk("align_err", {31'd0, align_err}, {31'd0, exp_align()});
      chk("retire_cnt", retire_cnt, m_retire);
      if (m_valid) begin
         chk("writereg", {27'd0, writereg}, {27'd0, m_dest});
         chk("writedata", writedata, exp_wd());
      end
   endtask

   // One clock: check combinational outputs, then the registered ones after the edge.
   task automatic cyc();
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, !stall});
`ifdef WB_BYPASS_EN
      begin
         logic rh, th;
         rh = exp_write() && (rs_addr == m_dest);
         th = exp_write() && (rt_addr == m_dest);
         chk("rs_hit", {31'd0, rs_hit}, {31'd0, rh});
         chk("rt_hit", {31'd0, rt_hit}, {31'd0, th});
         chk("rs_fwd", rs_fwd, rh ? exp_wd() : 32'd0);
         chk("rt_fwd", rt_fwd, th ? exp_wd() : 32'd0);
      end
`endif
      @(posedge clk);
      model_edge();
      #1;
      compare_outputs();
   endtask

   task automatic drive(input logic rw, input logic mtr, input logic lnk, input logic uns,
                        input logic [1:0] sz, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [4:0] dst);
      in_valid = 1; stall = 0; flush = 0;
      reg_write = rw; mem_to_reg = mtr; link = lnk; load_unsigned = uns; load_size = sz;
      alu_result = alu; mem_rd_data = mem; pc_plus8 = 32'h0000_1008; dest_reg = dst;
   endtask

   task automatic bubble();
      in_valid = 0; stall = 0; flush = 0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_write"}, {31'd0, write}, 32'd0);
      chk({tag, "_writereg"}, {27'd0, writereg}, 32'd0);
      chk({tag, "_writedata"}, writedata, 32'd0);
      chk({tag, "_align_err"}, {31'd0, align_err}, 32'd0);
      chk({tag, "_retire"}, retire_cnt, 32'd0);
   endtask

   initial begin
      rst = 1; bubble();
      drive(0, 0, 0, 0, 2'b00, 0, 0, 0); in_valid = 0;
`ifdef WB_BYPASS_EN
      rs_addr = 0; rt_addr = 0;
`endif
      model_reset();
      #12;
      chk_reset_outputs("reset");
      @(negedge clk); rst = 0;

      // lb, signed, address lane 1
      drive(1, 1, 0, 0, 2'b10, 32'h0000_1001, 32'h12F4_5678, 5'd3);
      cyc();
      chk("lb_write", {31'd0, write}, 32'd1);
      chk("lb_data", writedata, 32'hFFFF_FFF4);
      chk("lb_retire", retire_cnt, 32'd0);
      bubble(); cyc();
      chk("lb_retired", retire_cnt, 32'd1);

      // lhu at lane 2, then misaligned lh
      drive(1, 1, 0, 1, 2'b01, 32'h0000_2002, 32'h1234_ABCD, 5'd5);
      cyc();
      chk("lhu_data", writedata, 32'h0000_ABCD);
      chk("lhu_write", {31'd0, write}, 32'd1);
      drive(1, 1, 0, 0, 2'b01, 32'h0000_2001, 32'h1234_ABCD, 5'd5);
      cyc();
      chk("lh_align_err", {31'd0, align_err}, 32'd1);
      chk("lh_write", {31'd0, write}, 32'd0);
      bubble(); cyc();
      chk("lh_retired", retire_cnt, 32'd3);

      // write to $zero is suppressed but still retires
      drive(1, 0, 0, 0, 2'b00, 32'd5, 32'd0, 5'd0);
      cyc();
      chk("r0_write", {31'd0, write}, 32'd0);
      bubble(); cyc();
      chk("r0_retired", retire_cnt, 32'd4);

      // entry followed by a three-cycle stall
      drive(1, 0, 0, 0, 2'b00, 32'h55, 32'd0, 5'd7);
      cyc();
      chk("stall_first_write", {31'd0, write}, 32'd1);
      in_valid = 0; stall = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_write", {31'd0, write}, 32'd0);
      end
      bubble(); cyc();
      chk("stall_retired", retire_cnt, 32'd5);

      // flush together with a valid input
      drive(1, 0, 0, 0, 2'b00, 32'h99, 32'd0, 5'd9);
      flush = 1;
      cyc();
      chk("flush_write", {31'd0, write}, 32'd0);
      chk("flush_retire", retire_cnt, 32'd5);
      bubble();

      // reset while an entry is held in stall
      drive(1, 0, 0, 0, 2'b00, 32'h77, 32'd0, 5'd4);
      cyc();
      chk("pre_rst_write", {31'd0, write}, 32'd1);
      in_valid = 0; stall = 1;
      cyc();
      chk("pre_rst_retire", retire_cnt, 32'd6);
      #2 rst = 1;
      #1;
      chk_reset_outputs("midstall_rst");
      model_reset();
      @(negedge clk); rst = 0; bubble();

`ifdef WB_BYPASS_EN
      drive(1, 0, 0, 0, 2'b00, 32'd10, 32'd0, 5'd16);
      cyc();
      rs_addr = 5'd16; rt_addr = 5'd3;
      #1;
      chk("byp_rs_hit", {31'd0, rs_hit}, 32'd1);
      chk("byp_rs_fwd", rs_fwd, 32'd10);
      chk("byp_rt_hit", {31'd0, rt_hit}, 32'd0);
      bubble();
`endif

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         in_valid      = ($urandom_range(0, 9) < 7);
         stall         = ($urandom_range(0, 3) == 0);
         flush         = ($urandom_range(0, 9) == 0);
         reg_write     = ($urandom_range(0, 9) < 8);
         mem_to_reg    = ($urandom_range(0, 9) < 4);
         link          = ($urandom_range(0, 9) < 2);
         load_unsigned = $urandom_range(0, 1);
         load_size     = 2'($urandom_range(0, 2));
         alu_result    = $urandom;
         mem_rd_data   = $urandom;
         pc_plus8      = $urandom;
         dest_reg      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
`ifdef WB_BYPASS_EN
         rs_addr       = ($urandom_range(0, 1) == 1) ? m_dest : 5'($urandom);
         rt_addr       = 5'($urandom);
`endif
         if (n == 1500) begin
            rst = 1;
            model_reset();
         end else begin
            rst = 0;
         end
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
